alu_issue_ctrl: RTL and testbench

//  Initiator side of the ALU port: a 2-stage valid/ready unit that decodes RV32I OP, OP-IMM and BRANCH

---
 rtl/alu_issue_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Two-stage valid/ready issue unit: decodes RV32I OP/OP-IMM/BRANCH into ALU opcodes,
// drives the ALU from the issue stage and captures its result into the output stage.
module alu_issue_ctrl #(
  parameter int TAG_W        = 5,
  parameter bit DROP_ILLEGAL = 1'b0
) (
  input  logic             CLK_i,
  input  logic             RST_i,
  input  logic             IN_VALID_i,
  output logic             IN_READY_o,
  input  logic [31:0]      IN_INSTR_i,
  input  logic [31:0]      IN_RS1_i,
  input  logic [31:0]      IN_RS2_i,
  input  logic [TAG_W-1:0] IN_TAG_i,
  output logic [3:0]       ALU_OP_o,
  output logic [31:0]      ALU_RS1_o,
  output logic [31:0]      ALU_RS2_o,
  input  logic [31:0]      ALU_RD_i,
  input  logic             ALU_ZR_i,
  output logic             OUT_VALID_o,
  input  logic             OUT_READY_i,
  output logic [31:0]      OUT_RESULT_o,
  output logic             OUT_BRANCH_o,
  output logic             OUT_TAKEN_o,
  output logic             OUT_ILLEGAL_o,
  output logic [TAG_W-1:0] OUT_TAG_o
);

  localparam logic [3:0] OP_AND  = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB  = 4'b1010, OP_EQ  = 4'b0011, OP_SLL = 4'b0100,
                         OP_SRL  = 4'b0101, OP_SRA = 4'b0111, OP_XOR = 4'b1000,
                         OP_GE   = 4'b1100, OP_GEU = 4'b1101, OP_SLT = 4'b1110,
                         OP_SLTU = 4'b1111;

  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011, OPC_BR = 7'b1100011;

  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm, w_shamt;
  logic        w_alt;
  logic [3:0]  w_op;
  logic [31:0] w_a, w_b;
  logic        w_br, w_inv, w_ill;
  logic        w_unused;

  assign w_opc    = IN_INSTR_i[6:0];
  assign w_f3     = IN_INSTR_i[14:12];
  assign w_f7     = IN_INSTR_i[31:25];
  assign w_imm    = {{20{IN_INSTR_i[31]}}, IN_INSTR_i[31:20]};
  assign w_shamt  = {27'b0, IN_INSTR_i[24:20]};
  assign w_alt    = (w_f7 == 7'b0100000);
  assign w_unused = &{1'b0, IN_INSTR_i[11:7]};

  always_comb begin
    w_op  = OP_AND;
    w_a   = IN_RS1_i;
    w_b   = IN_RS2_i;
    w_br  = 1'b0;
    w_inv = 1'b0;
    w_ill = 1'b0;
    case (w_opc)
      OPC_OP: begin
        if (!((w_f7 == 7'b0) || (w_alt && (w_f3 == 3'b000 || w_f3 == 3'b101))))
          w_ill = 1'b1;
        case (w_f3)
          3'b000:  w_op = w_alt ? OP_SUB : OP_ADD;
          3'b001:  w_op = OP_SLL;
          3'b010:  w_op = OP_SLT;
          3'b011:  w_op = OP_SLTU;
          3'b100:  w_op = OP_XOR;
          3'b101:  w_op = w_alt ? OP_SRA : OP_SRL;
          3'b110:  w_op = OP_OR;
          default: w_op = OP_AND;
        endcase
      end
      OPC_IMM: begin
        w_b = w_imm;
        case (w_f3)
          3'b000:  w_op = OP_ADD;
          3'b001: begin
            w_op  = OP_SLL;
            w_b   = w_shamt;
            w_ill = (w_f7 != 7'b0);
          end
          3'b010:  w_op = OP_SLT;
          3'b011:  w_op = OP_SLTU;
          3'b100:  w_op = OP_XOR;
          3'b101: begin
            w_op  = IN_INSTR_i[30] ? OP_SRA : OP_SRL;
            w_b   = w_shamt;
            w_ill = !((w_f7 == 7'b0) || w_alt);
          end
          3'b110:  w_op = OP_OR;
          default: w_op = OP_AND;
        endcase
      end
      OPC_BR: begin
        w_br = 1'b1;
        case (w_f3)
          3'b000:  w_op = OP_EQ;
          3'b001: begin
            w_op  = OP_EQ;
            w_inv = 1'b1;
          end
          3'b100:  w_op = OP_SLT;
          3'b101:  w_op = OP_GE;
          3'b110:  w_op = OP_SLTU;
          3'b111:  w_op = OP_GEU;
          default: w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    // illegal entries run a harmless AND 0,0 so the ALU yields 0
    if (w_ill) begin
      w_op  = OP_AND;
      w_a   = '0;
      w_b   = '0;
      w_br  = 1'b0;
      w_inv = 1'b0;
    end
  end

  logic             r_a_vld, r_a_br, r_a_inv, r_a_ill;
  logic [3:0]       r_a_op;
  logic [31:0]      r_a_rs1, r_a_rs2;
  logic [TAG_W-1:0] r_a_tag;

  logic             r_o_vld, r_o_br, r_o_tk, r_o_ill;
  logic [31:0]      r_o_res;
  logic [TAG_W-1:0] r_o_tag;

  logic w_b_can, w_a_drop, w_b_load, w_a_free, w_in_fire;

  assign w_b_can   = !r_o_vld || OUT_READY_i;
  assign w_a_drop  = DROP_ILLEGAL && r_a_ill;
  assign w_b_load  = r_a_vld && w_b_can && !w_a_drop;
  assign w_a_free  = !r_a_vld || w_b_can || w_a_drop;
  assign w_in_fire = IN_VALID_i && w_a_free;

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_a_vld <= 1'b0;
      r_a_op  <= '0;
      r_a_rs1 <= '0;
      r_a_rs2 <= '0;
      r_a_br  <= 1'b0;
      r_a_inv <= 1'b0;
      r_a_ill <= 1'b0;
      r_a_tag <= '0;
    end else if (w_in_fire) begin
      r_a_vld <= 1'b1;
      r_a_op  <= w_op;
      r_a_rs1 <= w_a;
      r_a_rs2 <= w_b;
      r_a_br  <= w_br;
      r_a_inv <= w_inv;
      r_a_ill <= w_ill;
      r_a_tag <= IN_TAG_i;
    end else if (w_a_free) begin
      r_a_vld <= 1'b0;
    end
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_o_vld <= 1'b0;
      r_o_res <= '0;
      r_o_br  <= 1'b0;
      r_o_tk  <= 1'b0;
      r_o_ill <= 1'b0;
      r_o_tag <= '0;
    end else if (w_b_load) begin
      r_o_vld <= 1'b1;
      r_o_res <= ALU_RD_i;
      r_o_br  <= r_a_br;
      r_o_tk  <= r_a_br && (r_a_inv ? ALU_ZR_i : !ALU_ZR_i);
      r_o_ill <= r_a_ill;
      r_o_tag <= r_a_tag;
    end else if (OUT_READY_i) begin
      r_o_vld <= 1'b0;
    end
  end

  assign IN_READY_o    = w_a_free;
  assign ALU_OP_o      = r_a_op;
  assign ALU_RS1_o     = r_a_rs1;
  assign ALU_RS2_o     = r_a_rs2;
  assign OUT_VALID_o   = r_o_vld;
  assign OUT_RESULT_o  = r_o_res;
  assign OUT_BRANCH_o  = r_o_br;
  assign OUT_TAKEN_o   = r_o_tk;
  assign OUT_ILLEGAL_o = r_o_ill;
  assign OUT_TAG_o     = r_o_tag;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, stall/reset/drop sequences and a
// randomized run scored against an instruction-level reference model.
module tb_alu_issue_ctrl;
  localparam int TAG_W = 5;

  logic CLK_i = 1'b0;
  logic RST_i = 1'b1;
  always #5 CLK_i = ~CLK_i;

  logic             in_valid, in_ready, alu_zr, out_valid, out_ready;
  logic [31:0]      instr, rs1, rs2, alu_rs1, alu_rs2, alu_rd, out_result;
  logic [TAG_W-1:0] tag, out_tag;
  logic [3:0]       alu_op;
  logic             out_branch, out_taken, out_illegal;

  logic             d_in_valid, d_in_ready, d_alu_zr, d_out_valid, d_out_branch, d_out_taken, d_out_illegal;
  logic [31:0]      d_instr, d_rs1, d_rs2, d_alu_rs1, d_alu_rs2, d_alu_rd, d_out_result;
  logic [TAG_W-1:0] d_out_tag;
  logic [3:0]       d_alu_op;

  // ALU stand-in driven by the issue stage
  function automatic logic [31:0] alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b1010: return a - b;
      4'b0011: return {31'b0, a == b};
      4'b0100: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b0111: return $signed(a) >>> b[4:0];
      4'b1000: return a ^ b;
      4'b1100: return {31'b0, $signed(a) >= $signed(b)};
      4'b1101: return {31'b0, a >= b};
      4'b1110: return {31'b0, $signed(a) < $signed(b)};
      4'b1111: return {31'b0, a < b};
      default: return 32'b0;
    endcase
  endfunction

  assign alu_rd   = alu_f(alu_op, alu_rs1, alu_rs2);
  assign alu_zr   = (alu_rd == 32'b0);
  assign d_alu_rd = alu_f(d_alu_op, d_alu_rs1, d_alu_rs2);
  assign d_alu_zr = (d_alu_rd == 32'b0);

  alu_issue_ctrl #(.TAG_W(TAG_W), .DROP_ILLEGAL(1'b0)) dut (
    .CLK_i(CLK_i), .RST_i(RST_i), .IN_VALID_i(in_valid), .IN_READY_o(in_ready),
    .IN_INSTR_i(instr), .IN_RS1_i(rs1), .IN_RS2_i(rs2), .IN_TAG_i(tag),
    .ALU_OP_o(alu_op), .ALU_RS1_o(alu_rs1), .ALU_RS2_o(alu_rs2), .ALU_RD_i(alu_rd), .ALU_ZR_i(alu_zr),
    .OUT_VALID_o(out_valid), .OUT_READY_i(out_ready), .OUT_RESULT_o(out_result),
    .OUT_BRANCH_o(out_branch), .OUT_TAKEN_o(out_taken), .OUT_ILLEGAL_o(out_illegal), .OUT_TAG_o(out_tag));

  alu_issue_ctrl #(.TAG_W(TAG_W), .DROP_ILLEGAL(1'b1)) dut_d (
    .CLK_i(CLK_i), .RST_i(RST_i), .IN_VALID_i(d_in_valid), .IN_READY_o(d_in_ready),
    .IN_INSTR_i(d_instr), .IN_RS1_i(d_rs1), .IN_RS2_i(d_rs2), .IN_TAG_i(5'd0),
    .ALU_OP_o(d_alu_op), .ALU_RS1_o(d_alu_rs1), .ALU_RS2_o(d_alu_rs2), .ALU_RD_i(d_alu_rd), .ALU_ZR_i(d_alu_zr),
    .OUT_VALID_o(d_out_valid), .OUT_READY_i(1'b1), .OUT_RESULT_o(d_out_result),
    .OUT_BRANCH_o(d_out_branch), .OUT_TAKEN_o(d_out_taken), .OUT_ILLEGAL_o(d_out_illegal), .OUT_TAG_o(d_out_tag));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]      res;
    logic             br, tk, ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  // Architectural meaning of each instruction, straight from the ISA rules
  function automatic exp_t ref_model(logic [31:0] ins, logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] t);
    exp_t e;
    logic [2:0]  f3  = ins[14:12];
    logic [6:0]  f7  = ins[31:25];
    logic [31:0] imm = {{20{ins[31]}}, ins[31:20]};
    logic [4:0]  sh  = ins[24:20];
    e = '{res: 32'b0, br: 1'b0, tk: 1'b0, ill: 1'b0, tag: t};
    case (ins[6:0])
      7'h33: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          case (f3)
            3'd0: e.res = (f7 == 7'h20) ? a - b : a + b;
            3'd1: e.res = a << b[4:0];
            3'd2: e.res = {31'b0, $signed(a) < $signed(b)};
            3'd3: e.res = {31'b0, a < b};
            3'd4: e.res = a ^ b;
            3'd5: e.res = (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: e.res = a | b;
            default: e.res = a & b;
          endcase
        end else e.ill = 1'b1;
      end
      7'h13: begin
        case (f3)
          3'd0: e.res = a + imm;
          3'd1: if (f7 == 7'h00) e.res = a << sh; else e.ill = 1'b1;
          3'd2: e.res = {31'b0, $signed(a) < $signed(imm)};
          3'd3: e.res = {31'b0, a < imm};
          3'd4: e.res = a ^ imm;
          3'd5: if (f7 == 7'h00) e.res = a >> sh;
                else if (f7 == 7'h20) e.res = 32'($signed(a) >>> sh);
                else e.ill = 1'b1;
          3'd6: e.res = a | imm;
          default: e.res = a & imm;
        endcase
      end
      7'h63: begin
        e.br = 1'b1;
        case (f3)
          3'd0: begin e.res = {31'b0, a == b}; e.tk = (a == b); end
          3'd1: begin e.res = {31'b0, a == b}; e.tk = (a != b); end
          3'd4: begin e.res = {31'b0, $signed(a) < $signed(b)};  e.tk = $signed(a) < $signed(b); end
          3'd5: begin e.res = {31'b0, $signed(a) >= $signed(b)}; e.tk = $signed(a) >= $signed(b); end
          3'd6: begin e.res = {31'b0, a < b};  e.tk = (a < b); end
          3'd7: begin e.res = {31'b0, a >= b}; e.tk = (a >= b); end
          default: e.ill = 1'b1;
        endcase
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.res = 32'b0;
      e.br  = 1'b0;
      e.tk  = 1'b0;
    end
    return e;
  endfunction

  exp_t             q[$];
  logic             hold_v = 1'b0, last_in_fire = 1'b0;
  logic [31:0]      h_res;
  logic [TAG_W-1:0] h_tag;

  // Called at a negedge after inputs are set: scores handshakes due at the next edge
  task automatic tick();
    exp_t e;
    #1;
    if (hold_v) begin
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_result", out_result, h_res);
      chk("hold_tag", {27'b0, out_tag}, {27'b0, h_tag});
    end
    hold_v = out_valid && !out_ready;
    h_res  = out_result;
    h_tag  = out_tag;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("sb_unexpected_out", {31'b0, out_valid}, 32'd0);
      else begin
        e = q.pop_front();
        chk("sb_result", out_result, e.res);
        chk("sb_branch", {31'b0, out_branch}, {31'b0, e.br});
        chk("sb_taken", {31'b0, out_taken}, {31'b0, e.tk});
        chk("sb_illegal", {31'b0, out_illegal}, {31'b0, e.ill});
        chk("sb_tag", {27'b0, out_tag}, {27'b0, e.tag});
      end
    end
    last_in_fire = in_valid && in_ready;
    if (last_in_fire) q.push_back(ref_model(instr, rs1, rs2, tag));
    @(negedge CLK_i);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r = $urandom;
    logic [6:0]  f7;
    int          k = $urandom_range(0, 9);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    if (k <= 3)      return {f7, r[24:7], 7'h33};
    else if (k <= 6) return {f7, r[24:7], 7'h13};
    else if (k <= 8) return {r[31:7], 7'h63};
    else             return $urandom;
  endfunction

  typedef struct {
    logic [31:0] ins, a, b;
    logic [3:0]  op;
    logic [31:0] opb, res;
    logic        br, tk, ill;
  } vec_t;
  vec_t tv[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, acc, cnt;
    logic [31:0] dres;
    tv[0]  = '{{7'h00,5'd2,5'd1,3'd0,5'd3,7'h33}, 32'd5, 32'd7, 4'b0010, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{{7'h20,5'd2,5'd1,3'd0,5'd3,7'h33}, 32'd0, 32'd1, 4'b1010, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{{7'h20,5'd4,5'd1,3'd5,5'd3,7'h13}, 32'h80000000, 32'h12345678, 4'b0111, 32'd4, 32'hF8000000, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{{7'h00,5'd2,5'd1,3'd4,5'd0,7'h63}, 32'hFFFFFFFF, 32'd1, 4'b1110, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0};
    tv[4]  = '{{7'h00,5'd2,5'd1,3'd1,5'd0,7'h63}, 32'h55, 32'h55, 4'b0011, 32'h55, 32'd1, 1'b1, 1'b0, 1'b0};
    tv[5]  = '{32'h0000007F, 32'hAB, 32'hAB, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1};
    tv[6]  = '{{7'h01,5'd2,5'd1,3'd0,5'd3,7'h33}, 32'd3, 32'd4, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1};
    tv[7]  = '{{7'h00,5'd2,5'd1,3'd0,5'd0,7'h63}, 32'd9, 32'd9, 4'b0011, 32'd9, 32'd1, 1'b1, 1'b1, 1'b0};
    tv[8]  = '{{12'hFFF,5'd1,3'd3,5'd3,7'h13}, 32'd5, 32'd0, 4'b1111, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{{7'h20,5'd3,5'd1,3'd1,5'd3,7'h13}, 32'd6, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1};
    tv[10] = '{{7'h00,5'd2,5'd1,3'd7,5'd0,7'h63}, 32'd1, 32'hFFFFFFFF, 4'b1101, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1'b0};
    tv[11] = '{{7'h00,5'd2,5'd1,3'd2,5'd0,7'h63}, 32'd10, 32'd10, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1};
    tv[12] = '{{7'h20,5'd2,5'd1,3'd5,5'd3,7'h33}, 32'hF0000000, 32'h24, 4'b0111, 32'h24, 32'hFF000000, 1'b0, 1'b0, 1'b0};
    tv[13] = '{{7'h00,5'd2,5'd1,3'd5,5'd0,7'h63}, 32'hFFFFFFFE, 32'hFFFFFFFE, 4'b1100, 32'hFFFFFFFE, 32'd1, 1'b1, 1'b1, 1'b0};

    in_valid = 0; instr = 0; rs1 = 0; rs2 = 0; tag = 0; out_ready = 0;
    d_in_valid = 0; d_instr = 0; d_rs1 = 0; d_rs2 = 0;

    // reset state
    repeat (2) @(negedge CLK_i);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
    chk("rst_alu_rs1", alu_rs1, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    RST_i = 1'b0;
    #1 chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge CLK_i);

    // directed vectors, one at a time
    for (int i = 0; i < 14; i++) begin
      in_valid = 1; instr = tv[i].ins; rs1 = tv[i].a; rs2 = tv[i].b; tag = 5'(i); out_ready = 1;
      tick();
      in_valid = 0;
      chk($sformatf("v%0d_alu_op", i), {28'b0, alu_op}, {28'b0, tv[i].op});
      chk($sformatf("v%0d_alu_b", i), alu_rs2, tv[i].opb);
      tick();
      chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("v%0d_result", i), out_result, tv[i].res);
      chk($sformatf("v%0d_branch", i), {31'b0, out_branch}, {31'b0, tv[i].br});
      chk($sformatf("v%0d_taken", i), {31'b0, out_taken}, {31'b0, tv[i].tk});
      chk($sformatf("v%0d_illegal", i), {31'b0, out_illegal}, {31'b0, tv[i].ill});
      tick();
    end

    // back-to-back with consumer stalled for 5 cycles
    t = 1; acc = 0; out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; instr = {7'h00,5'd2,5'd1,3'd0,5'd3,7'h33}; rs1 = $urandom; rs2 = $urandom; tag = 5'(t);
      tick();
      if (last_in_fire) begin acc++; t++; end
    end
    chk("stall_accepts", acc, 32'd2);
    #1 chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      tag = 5'(t); rs1 = $urandom;
      tick();
      if (last_in_fire) t++;
    end
    in_valid = 0;
    repeat (4) tick();
    chk("stall_drained", q.size(), 32'd0);

    // DROP_ILLEGAL=1: two illegals then an add; only the add surfaces
    cnt = 0; dres = 32'hDEADBEEF;
    for (int c = 0; c < 10; c++) begin
      d_in_valid = (c < 3);
      d_instr = (c == 0) ? 32'h0000007F : (c == 1) ? {7'h01,5'd2,5'd1,3'd0,5'd3,7'h33}
                                                   : {7'h00,5'd2,5'd1,3'd0,5'd3,7'h33};
      d_rs1 = 32'd5; d_rs2 = 32'd7;
      #1;
      if (c < 3) chk($sformatf("drop_in_ready%0d", c), {31'b0, d_in_ready}, 32'd1);
      if (d_out_valid) begin
        cnt++; dres = d_out_result;
        chk("drop_illegal_flag", {31'b0, d_out_illegal}, 32'd0);
      end
      @(negedge CLK_i);
    end
    d_in_valid = 0;
    chk("drop_out_count", cnt, 32'd1);
    chk("drop_result", dres, 32'd12);

    // randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      instr = gen_instr(); rs1 = $urandom;
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      tag = 5'($urandom);
      tick();
    end
    in_valid = 0; out_ready = 1;
    repeat (4) tick();
    chk("rand_drained", q.size(), 32'd0);

    // reset with both stages full
    out_ready = 0; in_valid = 1; instr = {7'h00,5'd2,5'd1,3'd0,5'd3,7'h33}; rs1 = 32'h11; rs2 = 32'h22;
    tick(); tick();
    in_valid = 0;
    #1 chk("mid_full", {31'b0, out_valid}, 32'd1);
    chk("mid_a_op", {28'b0, alu_op}, 32'd2);
    #1 RST_i = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_alu_op", {28'b0, alu_op}, 32'd0);
    chk("mid_rst_alu_rs1", alu_rs1, 32'd0);
    chk("mid_rst_alu_rs2", alu_rs2, 32'd0);
    chk("mid_rst_out_tag", {27'b0, out_tag}, 32'd0);
    q.delete(); hold_v = 0;
    @(negedge CLK_i);
    RST_i = 1'b0; out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("mid_no_stale", {31'b0, out_valid}, 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
